// File: rtl/lab1_pkg.sv
// Shared definitions for the Lab1 random-number display path.
// Holds the roll controller state encoding and the default parameter
// values, so the LFSR bench and the top level agree on them.
package lab1_pkg;

  typedef enum logic {S_IDLE, S_ROLL} roll_state_t;

  localparam int unsigned DEF_DATA_W        = 16;
  localparam int unsigned DEF_OUT_W         = 4;
  localparam int unsigned DEF_INIT_INTERVAL = 4;
  localparam int unsigned DEF_MAX_INTERVAL  = 16;
  localparam int unsigned DEF_NUM_STEPS     = 4;

endpackage

// File: rtl/rand_roll_ctrl_if.sv
// Signal bundle between the roll controller and its environment.
// Signals:
//   i_start      - one-cycle start/restart pulse
//   i_lfsr_data  - free-running LFSR word, valid every cycle
//   o_random_out - displayed value (low OUT_W bits of the last sample)
//   o_update     - one-cycle pulse after o_random_out changes
//   o_busy       - high while a roll is in progress
//   o_done       - one-cycle pulse after the final sample
// Modports: master drives the inputs of the controller, slave is the
// controller itself.
interface rand_roll_ctrl_if
  import lab1_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
);

  logic              i_start;
  logic [DATA_W-1:0] i_lfsr_data;
  logic [OUT_W-1:0]  o_random_out;
  logic              o_update;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_lfsr_data,
    input  o_random_out, o_update, o_busy, o_done
  );

  modport slave (
    input  i_start, i_lfsr_data,
    output o_random_out, o_update, o_busy, o_done
  );

endinterface

// File: rtl/rand_roll_ctrl_interval_timer.sv
// roll_interval_timer: spacing generator for the roll samples.
// Counts cycles up to the current interval and doubles the interval
// (saturating at MAX_INTERVAL) every time it expires.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - restart: tick_cnt <= 0, interval <= INIT_INTERVAL
//   advance    - count one cycle (ignored while load is high)
//   expire     - high when tick_cnt == interval-1 (sample edge)
module roll_interval_timer
  import lab1_pkg::*;
#(
  parameter int unsigned INIT_INTERVAL = DEF_INIT_INTERVAL,
  parameter int unsigned MAX_INTERVAL  = DEF_MAX_INTERVAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(MAX_INTERVAL + 1);

  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] interval_next;
  logic [CNT_W:0]   doubled;

  // Doubling is one bit wider than the interval so the compare against
  // the ceiling sees the true value rather than a wrapped one.
  always_comb begin
    doubled = {interval, 1'b0};
    if (doubled > (CNT_W + 1)'(MAX_INTERVAL))
      interval_next = CNT_W'(MAX_INTERVAL);
    else
      interval_next = doubled[CNT_W-1:0];
  end

  assign expire = (tick_cnt == interval - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      interval <= '0;
    end else if (load) begin
      tick_cnt <= '0;
      interval <= CNT_W'(INIT_INTERVAL);
    end else if (advance) begin
      if (expire) begin
        tick_cnt <= '0;
        interval <= interval_next;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rand_roll_ctrl.sv
// rand_roll_ctrl: samples the LFSR word at progressively longer
// intervals after a start pulse so the display "rolls" and slows down,
// then freezes the final value and pulses done.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   bus     - rand_roll_ctrl_if.slave (start, LFSR word, display outputs)
module rand_roll_ctrl
  import lab1_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned OUT_W         = DEF_OUT_W,
  parameter int unsigned INIT_INTERVAL = DEF_INIT_INTERVAL,
  parameter int unsigned MAX_INTERVAL  = DEF_MAX_INTERVAL,
  parameter int unsigned NUM_STEPS     = DEF_NUM_STEPS
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rand_roll_ctrl_if.slave bus
);

  localparam int unsigned STEP_W = $clog2(NUM_STEPS + 1);

  roll_state_t       state, state_next;
  logic [STEP_W-1:0] step_cnt;
  logic [OUT_W-1:0]  random_q;
  logic              update_q;
  logic              done_q;
  logic              expire;
  logic              sample;
  logic              last_sample;
  logic              unused_lfsr;

  // Only the low OUT_W bits are displayed; the rest of the word is
  // deliberately ignored.
  assign unused_lfsr = ^bus.i_lfsr_data;

  roll_interval_timer #(
    .INIT_INTERVAL (INIT_INTERVAL),
    .MAX_INTERVAL  (MAX_INTERVAL)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (bus.i_start),
    .advance (state == S_ROLL),
    .expire  (expire)
  );

  // A start pulse in ROLL re-initialises and suppresses a coincident sample.
  always_comb begin
    state_next  = state;
    sample      = 1'b0;
    last_sample = 1'b0;
    if (state == S_ROLL && !bus.i_start && expire) begin
      sample      = 1'b1;
      last_sample = (step_cnt == STEP_W'(NUM_STEPS - 1));
    end
    if (bus.i_start)
      state_next = S_ROLL;
    else if (last_sample)
      state_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      random_q <= '0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      update_q <= sample;
      done_q   <= last_sample;
      if (bus.i_start)
        step_cnt <= '0;
      else if (sample)
        step_cnt <= step_cnt + STEP_W'(1);
      if (sample)
        random_q <= bus.i_lfsr_data[OUT_W-1:0];
    end
  end

  assign bus.o_random_out = random_q;
  assign bus.o_update     = update_q;
  assign bus.o_done       = done_q;
  assign bus.o_busy       = (state == S_ROLL);

endmodule

// File: tb/tb_rand_roll_ctrl.sv
// Scoreboard bench for rand_roll_ctrl: stimulus pushes expected samples
// (cycle, value, done) into per-instance queues; negedge monitors pop and
// compare whenever o_update is seen.
module tb_rand_roll_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t0 = 0;
  int   t1 = 0;
  int   t_a = 0;
  bit   trk0 = 0;
  bit   trk1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  rand_roll_ctrl_if #(.DATA_W(16), .OUT_W(4)) b0 ();
  rand_roll_ctrl_if #(.DATA_W(16), .OUT_W(4)) b1 ();

  rand_roll_ctrl #(
    .DATA_W(16), .OUT_W(4), .INIT_INTERVAL(4), .MAX_INTERVAL(16), .NUM_STEPS(4)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0)
  );

  rand_roll_ctrl #(
    .DATA_W(16), .OUT_W(4), .INIT_INTERVAL(1), .MAX_INTERVAL(1), .NUM_STEPS(3)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input logic upd, input logic dn, input logic [3:0] val);
    exp_t  e;
    string p;
    int    sz;
    p  = (id == 0) ? "d0" : "d1";
    sz = (id == 0) ? q0.size() : q1.size();
    if (upd) begin
      if (sz == 0) begin
        chk({p, "_unexpected_update_cycle"}, cyc, -1);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk({p, "_update_cycle"}, cyc, e.cyc);
        chk({p, "_random_out"}, int'(val), int'(e.val));
        chk({p, "_done"}, int'(dn), int'(e.done));
      end
    end else if (dn) begin
      chk({p, "_done_without_update"}, 1, 0);
    end
  endtask

  always @(negedge clk) mon(0, b0.o_update, b0.o_done, b0.o_random_out);
  always @(negedge clk) mon(1, b1.o_update, b1.o_done, b1.o_random_out);

  task automatic push0(input int c, input logic [3:0] v, input logic d);
    q0.push_back('{cyc: c, val: v, done: d});
  endtask

  task automatic push1(input int c, input logic [3:0] v, input logic d);
    q1.push_back('{cyc: c, val: v, done: d});
  endtask

  // Advance to the next negedge; tracked LFSR words equal (edge - T).
  task automatic tick();
    @(negedge clk);
    if (trk0) b0.i_lfsr_data = 16'(cyc + 1 - t0);
    if (trk1) b1.i_lfsr_data = 16'(cyc + 1 - t1);
  endtask

  // Called at a negedge; the start is sampled on the very next edge (T).
  task automatic start0();
    t0 = cyc + 1;
    if (trk0) b0.i_lfsr_data = '0;
    b0.i_start = 1'b1;
    tick();
    b0.i_start = 1'b0;
  endtask

  task automatic start1();
    t1 = cyc + 1;
    if (trk1) b1.i_lfsr_data = '0;
    b1.i_start = 1'b1;
    tick();
    b1.i_start = 1'b0;
  endtask

  task automatic wait0(input int n);
    while (cyc < t0 + n) tick();
  endtask

  task automatic wait1(input int n);
    while (cyc < t1 + n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.i_start = 1'b0;
    b0.i_lfsr_data = '0;
    b1.i_start = 1'b0;
    b1.i_lfsr_data = '0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(b0.o_busy), 0);
    chk("rst_random_out", int'(b0.o_random_out), 0);
    chk("rst_update", int'(b0.o_update), 0);
    chk("rst_done", int'(b0.o_done), 0);
    chk("rst_d1_busy", int'(b1.o_busy), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(b0.o_busy), 0);

    // Basic roll with a constant word
    b0.i_lfsr_data = 16'hA5C3;
    start0();
    push0(t0 + 4, 4'h3, 1'b0);
    push0(t0 + 12, 4'h3, 1'b0);
    push0(t0 + 28, 4'h3, 1'b0);
    push0(t0 + 44, 4'h3, 1'b1);
    chk("basic_busy_rise", int'(b0.o_busy), 1);
    wait0(43);
    chk("basic_busy_before_last", int'(b0.o_busy), 1);
    wait0(44);
    chk("basic_busy_fall", int'(b0.o_busy), 0);

    // Tracking word, started on the edge right after done
    trk0 = 1;
    start0();
    push0(t0 + 4, 4'd4, 1'b0);
    push0(t0 + 12, 4'd12, 1'b0);
    push0(t0 + 28, 4'd12, 1'b0);
    push0(t0 + 44, 4'd12, 1'b1);
    chk("track_busy_back_to_back", int'(b0.o_busy), 1);
    wait0(46);
    trk0 = 0;

    // Restart at T+10
    b0.i_lfsr_data = 16'h0007;
    start0();
    t_a = t0;
    push0(t_a + 4, 4'h7, 1'b0);
    wait0(9);
    b0.i_lfsr_data = 16'h000B;
    start0();
    chk("restart_t0", t0, t_a + 10);
    push0(t0 + 4, 4'hB, 1'b0);
    push0(t0 + 12, 4'hB, 1'b0);
    push0(t0 + 28, 4'hB, 1'b0);
    push0(t0 + 44, 4'hB, 1'b1);
    wait0(3);
    chk("restart_hold_value", int'(b0.o_random_out), 7);
    chk("restart_busy", int'(b0.o_busy), 1);
    wait0(46);

    // Reset mid-roll
    b0.i_lfsr_data = 16'h00F9;
    start0();
    push0(t0 + 4, 4'h9, 1'b0);
    push0(t0 + 12, 4'h9, 1'b0);
    wait0(19);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(b0.o_busy), 0);
    chk("midrst_random_out", int'(b0.o_random_out), 0);
    chk("midrst_update", int'(b0.o_update), 0);
    chk("midrst_done", int'(b0.o_done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait0(70);
    chk("midrst_queue_drained", q0.size(), 0);
    b0.i_lfsr_data = 16'h1234;
    start0();
    push0(t0 + 4, 4'h4, 1'b0);
    push0(t0 + 12, 4'h4, 1'b0);
    push0(t0 + 28, 4'h4, 1'b0);
    push0(t0 + 44, 4'h4, 1'b1);
    wait0(46);

    // Edge parameters: INIT=1, MAX=1, NUM_STEPS=3
    trk1 = 1;
    start1();
    push1(t1 + 1, 4'd1, 1'b0);
    push1(t1 + 2, 4'd2, 1'b0);
    push1(t1 + 3, 4'd3, 1'b1);
    chk("d1_busy_rise", int'(b1.o_busy), 1);
    wait1(2);
    chk("d1_busy_mid", int'(b1.o_busy), 1);
    wait1(3);
    chk("d1_busy_fall", int'(b1.o_busy), 0);
    wait1(6);
    trk1 = 0;

    chk("d0_queue_empty", q0.size(), 0);
    chk("d1_queue_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
